// File: rtl/rat_io_pkg.sv
// rat_io_pkg: shared constants for the RAT peripheral responder.
//   - I/O port addresses seen on port_id
//   - ISTAT bit positions
package rat_io_pkg;

  // Port map
  localparam logic [7:0] PORT_SW    = 8'h20;  // R   synced switches
  localparam logic [7:0] PORT_BTN   = 8'h24;  // R   synced buttons, zero-extended
  localparam logic [7:0] PORT_TCTL  = 8'h30;  // R/W bit0 = timer enable
  localparam logic [7:0] PORT_TPER  = 8'h31;  // R/W timer period in ticks
  localparam logic [7:0] PORT_ISTAT = 8'h32;  // R/W1C interrupt status
  localparam logic [7:0] PORT_IMASK = 8'h33;  // R/W interrupt mask
  localparam logic [7:0] PORT_LED   = 8'h40;  // R/W LED register
  localparam logic [7:0] PORT_SSEG  = 8'h81;  // W   seven-segment data

  localparam int NUM_BTN = 4;

  // ISTAT layout: bit0 timer expiry, bits 4:1 button 3..0 rising edge
  localparam int ISTAT_TMR     = 0;
  localparam int ISTAT_BTN_LSB = 1;

endpackage

// File: rtl/io_sync_edge.sv
// io_sync: W-bit multi-flop synchronizer for asynchronous board inputs.
//   clk, rst_n   clock / async active-low reset
//   i_d [W]      asynchronous input
//   o_q [W]      synchronized level (STAGES cycles of latency)
//
// io_sync_edge: single-bit synchronizer followed by a rising-edge detector.
//   clk, rst_n   clock / async active-low reset
//   i_d          asynchronous input
//   o_level      synchronized level
//   o_rise       one-cycle pulse when o_level goes 0 -> 1
module io_sync #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [STAGES-1:0][W-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

module io_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_level,
  output logic o_rise
);

  logic w_level;
  logic r_prev;

  io_sync #(.W(1), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (i_d),
    .o_q   (w_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= 1'b0;
    else        r_prev <= w_level;
  end

  assign o_level = w_level;
  assign o_rise  = w_level & ~r_prev;

endmodule

// File: rtl/rat_io_responder.sv
// rat_io_responder: peripheral side of the RAT CPU port bus.
//   clk, rst_n   clock / async active-low reset
//   port_id      port address from the CPU
//   out_port     write data; committed at posedge clk when io_strb=1
//   io_strb      write strobe
//   in_port      read data, combinational decode of port_id
//   interrupt    registered level interrupt = |(ISTAT & IMASK)
//   switches     async slide switches (synchronized)
//   buttons      async push buttons (synchronized, rising edges -> ISTAT)
//   leds         LED register
//   sseg_data    seven-segment data register
// Holds the port register file, a prescaled interval timer and the
// interrupt status/mask logic.
module rat_io_responder
  import rat_io_pkg::*;
#(
  parameter int PRESCALE    = 1000,  // 2..65535
  parameter int SYNC_STAGES = 2      // >= 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  input  logic       io_strb,
  output logic [7:0] in_port,
  output logic       interrupt,
  input  logic [7:0] switches,
  input  logic [3:0] buttons,
  output logic [7:0] leds,
  output logic [7:0] sseg_data
);

  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

  // ---------------- input synchronizers ----------------
  logic [7:0]         w_sw_sync;
  logic [NUM_BTN-1:0] w_btn_lvl;
  logic [NUM_BTN-1:0] w_btn_rise;

  io_sync #(.W(8), .STAGES(SYNC_STAGES)) u_sw_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (switches),
    .o_q   (w_sw_sync)
  );

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    io_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_btn (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_d     (buttons[gi]),
      .o_level (w_btn_lvl[gi]),
      .o_rise  (w_btn_rise[gi])
    );
  end

  // ---------------- register file ----------------
  logic [7:0]  r_leds, r_sseg, r_tper, r_istat, r_imask, r_tick_cnt;
  logic        r_tctl_en, r_irq;
  logic [15:0] r_presc;

  logic w_wr_led, w_wr_sseg, w_wr_tctl, w_wr_tper, w_wr_istat, w_wr_imask;

  assign w_wr_led   = io_strb && (port_id == PORT_LED);
  assign w_wr_sseg  = io_strb && (port_id == PORT_SSEG);
  assign w_wr_tctl  = io_strb && (port_id == PORT_TCTL);
  assign w_wr_tper  = io_strb && (port_id == PORT_TPER);
  assign w_wr_istat = io_strb && (port_id == PORT_ISTAT);
  assign w_wr_imask = io_strb && (port_id == PORT_IMASK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_leds    <= '0;
      r_sseg    <= '0;
      r_tctl_en <= 1'b0;
      r_tper    <= '0;
      r_imask   <= '0;
    end else begin
      if (w_wr_led)   r_leds    <= out_port;
      if (w_wr_sseg)  r_sseg    <= out_port;
      if (w_wr_tctl)  r_tctl_en <= out_port[0];
      if (w_wr_tper)  r_tper    <= out_port;
      if (w_wr_imask) r_imask   <= out_port;
    end
  end

  // ---------------- prescaler / tick counter ----------------
  // Any TCTL/TPER write restarts the timer from a clean phase so the first
  // expiry after reprogramming is a full TPER*PRESCALE cycles away.
  logic w_tmr_clr, w_tick, w_expire;

  assign w_tmr_clr = w_wr_tctl | w_wr_tper;
  assign w_tick    = r_tctl_en && (r_presc == PRESC_LAST) && !w_tmr_clr;
  assign w_expire  = w_tick && (r_tper != 8'd0) && (r_tick_cnt == r_tper - 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc    <= '0;
      r_tick_cnt <= '0;
    end else if (w_tmr_clr) begin
      r_presc    <= '0;
      r_tick_cnt <= '0;
    end else if (!r_tctl_en) begin
      r_presc    <= '0;
    end else begin
      r_presc <= w_tick ? 16'd0 : r_presc + 16'd1;
      if (w_tick) begin
        // TPER=0 means no expiry: counter parks at 0
        if (r_tper == 8'd0 || w_expire) r_tick_cnt <= '0;
        else                            r_tick_cnt <= r_tick_cnt + 8'd1;
      end
    end
  end

  // ---------------- interrupt status / request ----------------
  logic [7:0] w_istat_set, w_istat_clr;

  always_comb begin
    w_istat_set                              = '0;
    w_istat_set[ISTAT_TMR]                   = w_expire;
    w_istat_set[ISTAT_BTN_LSB +: NUM_BTN]    = w_btn_rise;
    w_istat_clr                              = w_wr_istat ? out_port : 8'h00;
  end

  // Set is OR-ed in after the clear so a same-cycle event is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_istat <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_istat <= (r_istat & ~w_istat_clr) | w_istat_set;
      r_irq   <= |(r_istat & r_imask);
    end
  end

  // ---------------- read mux ----------------
  always_comb begin
    in_port = 8'h00;
    case (port_id)
      PORT_SW:    in_port = w_sw_sync;
      PORT_BTN:   in_port = 8'(w_btn_lvl);
      PORT_LED:   in_port = r_leds;
      PORT_TCTL:  in_port = {7'b0, r_tctl_en};
      PORT_TPER:  in_port = r_tper;
      PORT_ISTAT: in_port = r_istat;
      PORT_IMASK: in_port = r_imask;
      default:    in_port = 8'h00;
    endcase
  end

  assign leds      = r_leds;
  assign sseg_data = r_sseg;
  assign interrupt = r_irq;

endmodule
